ripple_cnt_seq: RTL and testbench
=================================

# ripple_cnt_seq

Synchronous sequencer that drives a 4-bit asynchronous ripple up-counter from the system clock domain. It accepts count/clear commands over a valid/ready handshake and emits gated increment pulses and a counter clear. After each command it waits a fixed settle window for the ripple to propagate, then samples the counter and checks the value against a shadow expected count. The block sits between the test/control logic and the ripple counter, and is the only agent that clocks or clears it.

## Interface
- WIDTH, 4, counter width; also the width of cmd_n, cnt_q and rsp_value
- SETTLE, 3, idle cycles after the last counter edge before sampling; minimum 1

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  1  0 = COUNT, 1 = CLEAR
- cmd_n  in  WIDTH  increments for COUNT (0 = sample only); ignored for CLEAR
- cnt_pulse  out  1  registered increment clock to the ripple counter; one-cycle high pulses
- cnt_rst  out  1  registered active-high clear to the ripple counter
- cnt_q  in  WIDTH  ripple counter value; valid only after the settle window
- rsp_valid  out  1  result available
- rsp_ready  in  1  result consumed
- rsp_value  out  WIDTH  sampled cnt_q
- rsp_err  out  1  rsp_value != expected

## Operation
- FSM states: INIT, IDLE, CLR, PHI, PLO, SETTLE, RESP.
- INIT (reset state): cnt_rst=1. Next state is IDLE; exp=0.
- IDLE: cmd_ready=1. On cmd_valid:
  - COUNT with n>0 -> PHI; latch rem=n.
  - COUNT with n=0 -> SETTLE.
  - CLEAR -> CLR.
- CLR: cnt_rst=1 for 2 cycles; exp<=0; then SETTLE.
- PHI: cnt_pulse=1 for one cycle -> PLO.
- PLO: cnt_pulse=0; rem decrements. If rem>1 -> PHI, else -> SETTLE.
- SETTLE: wait SETTLE cycles. On the last cycle, capture cnt_q into rsp_value and compute rsp_err = (cnt_q != exp_target), where exp_target = (exp + n) mod 2^WIDTH, or 0 after CLEAR.
- SETTLE then goes to RESP. On a match, exp <= exp_target; on a mismatch, exp <= cnt_q, so the shadow resyncs to the hardware.
- RESP: rsp_valid=1, with rsp_value/rsp_err held stable until rsp_ready; then IDLE.
- Arithmetic is modulo 2^WIDTH; 15+3 wraps to 2.
- cnt_pulse and cnt_rst come straight from flops, never gated combinationally, and are never high together.
- Reset values: cnt_rst=1; cnt_pulse, cmd_ready, rsp_valid, rsp_err = 0; rsp_value=0; exp=0; state=INIT.
- Reset mid-operation: pulses stop at once, cnt_rst goes high, any pending response is discarded.

## Timing
- Accept cycle = cycle 0, i.e. the cycle where cmd_valid & cmd_ready.
- COUNT n>0: cnt_pulse high on cycles 1, 3, …, 2n-1. SETTLE occupies cycles 2n+1 … 2n+SETTLE. rsp_valid rises on cycle 2n+SETTLE+1.
- COUNT n=0: rsp_valid on cycle SETTLE+1.
- CLEAR: cnt_rst high on cycles 1–2; rsp_valid on cycle SETTLE+3.
- RESP -> IDLE on the cycle after rsp_valid & rsp_ready. cmd_ready rises on that next cycle; there is no back-to-back accept in the handshake cycle.
- After rst_n release: cnt_rst=1 for cycle 0 (INIT); cmd_ready=1 from cycle 1.
- cnt_q is sampled only on the final SETTLE cycle; glitches at any other time are ignored.

## Structure
- Shared package ripple_ctrl_pkg holds:
  - state enum (INIT, IDLE, CLR, PHI, PLO, SETTLE, RESP)
  - op constants OP_COUNT=0, OP_CLEAR=1
  - CLR_CYCLES=2
- A single down-counter, width max(WIDTH, clog2(SETTLE+1)), is shared between the pulse count and the settle wait.
- No RTL sub-module.
- The bench instantiates the ripple counter alongside the block: cnt_pulse drives its clock, cnt_rst its reset, and its output feeds cnt_q.

## Test plan
- Reset release -> cnt_rst=1 on cycle 0, cmd_ready=1 on cycle 1, rsp_valid=0, rsp_value=0.
- CLEAR, then COUNT n=5 (SETTLE=3) -> CLEAR gives rsp_value=0, err=0. COUNT gives 5 pulses on cycles 1,3,5,7,9; rsp_valid on cycle 14; rsp_value=5, err=0.
- COUNT 15, then COUNT 3 -> 15/err=0, then 2/err=0 (wrap). COUNT 0 -> rsp_value=2, no pulses, rsp_valid on cycle 4.
- Counter model drops one pulse during COUNT 3 from value 0 -> rsp_value=2, err=1. Next COUNT 1 -> rsp_value=3, err=0 (shadow resynced).
- rsp_ready held low 10 cycles -> rsp_valid, rsp_value, rsp_err stable; cmd_ready=0; no cnt_pulse/cnt_rst activity.
- rst_n pulled low during the 3rd pulse of COUNT 8 -> cnt_pulse=0 and cnt_rst=1 immediately, rsp_valid never asserts. After release, COUNT 2 -> rsp_value=2, err=0.

Source files
------------

// File: rtl/ripple_ctrl_pkg.sv
// Shared definitions for the ripple counter sequencer: FSM states,
// command opcodes, clear duration and the shared down-counter width.
package ripple_ctrl_pkg;

   typedef enum logic [2:0] {
      S_INIT,
      S_IDLE,
      S_CLR,
      S_PHI,
      S_PLO,
      S_SETTLE,
      S_RESP
   } state_t;

   localparam logic OP_COUNT   = 1'b0;
   localparam logic OP_CLEAR   = 1'b1;
   localparam int   CLR_CYCLES = 2;

   // One down-counter serves both the pulse count and the settle wait, so
   // it must hold the larger of a full command count and the settle length.
   function automatic int cnt_width(input int width, input int settle);
      int sw;
      sw = $clog2(settle + 1);
      return (width > sw) ? width : sw;
   endfunction

endpackage

// File: rtl/ripple_cnt_seq.sv
// Sequencer for an asynchronous ripple up-counter. Issues registered
// increment pulses and clears, waits for the ripple to settle, samples the
// counter and compares it against a shadow count of what it should hold.
module ripple_cnt_seq
   import ripple_ctrl_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int SETTLE = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_op,
   input  logic [WIDTH-1:0] cmd_n,
   output logic             cnt_pulse,
   output logic             cnt_rst,
   input  logic [WIDTH-1:0] cnt_q,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_value,
   output logic             rsp_err
);

   localparam int CW = cnt_width(WIDTH, SETTLE);

   state_t           state;
   logic [CW-1:0]    rem;       // pulses left, clear cycles left, or settle cycles left
   logic [WIDTH-1:0] exp_cnt;   // shadow of what the ripple counter should hold
   logic [WIDTH-1:0] target;    // expected counter value for the command in flight

   // Single FSM: every output is a flop, set on the transition into the
   // state that owns it, so cnt_pulse/cnt_rst never glitch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_INIT;
         cnt_rst   <= 1'b1;
         cnt_pulse <= 1'b0;
         cmd_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_value <= '0;
         exp_cnt   <= '0;
         target    <= '0;
         rem       <= '0;
      end else begin
         case (state)
            S_INIT: begin
               state     <= S_IDLE;
               cnt_rst   <= 1'b0;
               cmd_ready <= 1'b1;
               exp_cnt   <= '0;
            end

            S_IDLE: begin
               if (cmd_valid) begin
                  cmd_ready <= 1'b0;
                  if (cmd_op == OP_CLEAR) begin
                     state   <= S_CLR;
                     cnt_rst <= 1'b1;
                     rem     <= CW'(CLR_CYCLES - 1);
                     target  <= '0;
                  end else begin
                     target <= exp_cnt + cmd_n;
                     if (cmd_n != '0) begin
                        state     <= S_PHI;
                        cnt_pulse <= 1'b1;
                        rem       <= CW'(cmd_n);
                     end else begin
                        state <= S_SETTLE;
                        rem   <= CW'(SETTLE - 1);
                     end
                  end
               end
            end

            S_CLR: begin
               exp_cnt <= '0;
               if (rem == '0) begin
                  state   <= S_SETTLE;
                  cnt_rst <= 1'b0;
                  rem     <= CW'(SETTLE - 1);
               end else begin
                  rem <= rem - 1'b1;
               end
            end

            S_PHI: begin
               state     <= S_PLO;
               cnt_pulse <= 1'b0;
            end

            S_PLO: begin
               if (rem > CW'(1)) begin
                  state     <= S_PHI;
                  cnt_pulse <= 1'b1;
                  rem       <= rem - 1'b1;
               end else begin
                  state <= S_SETTLE;
                  rem   <= CW'(SETTLE - 1);
               end
            end

            S_SETTLE: begin
               if (rem == '0) begin
                  // Only this sample of cnt_q is trusted; on a mismatch the
                  // shadow adopts the hardware value so later checks resync.
                  state     <= S_RESP;
                  rsp_valid <= 1'b1;
                  rsp_value <= cnt_q;
                  rsp_err   <= (cnt_q != target);
                  exp_cnt   <= (cnt_q == target) ? target : cnt_q;
               end else begin
                  rem <= rem - 1'b1;
               end
            end

            S_RESP: begin
               if (rsp_ready) begin
                  state     <= S_IDLE;
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
               end
            end

            default: begin
               state     <= S_INIT;
               cnt_rst   <= 1'b1;
               cnt_pulse <= 1'b0;
               cmd_ready <= 1'b0;
               rsp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ripple_cnt_seq.sv
// Bench for ripple_cnt_seq: a behavioural ripple counter (with optional
// dropped pulse) sits on cnt_pulse/cnt_rst/cnt_q, commands are issued as
// directed steps and responses are checked against a queued model result.
module tb_ripple_cnt_seq;
   import ripple_ctrl_pkg::*;

   localparam int WIDTH  = 4;
   localparam int SETTLE = 3;

   logic             clk;
   logic             rst_n;
   logic             cmd_valid;
   logic             cmd_ready;
   logic             cmd_op;
   logic [WIDTH-1:0] cmd_n;
   logic             cnt_pulse;
   logic             cnt_rst;
   logic [WIDTH-1:0] cnt_q;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_value;
   logic             rsp_err;

   typedef struct {
      logic [WIDTH-1:0] val;
      logic             err;
      int               lat;
      logic [63:0]      pmask;
      logic [63:0]      rmask;
   } exp_t;

   exp_t sb[$];
   int   compared   = 0;
   int   mismatched = 0;
   int   exp_m;
   int   hw_m;
   int   pulses_seen = 0;
   int   drop_at;

   ripple_cnt_seq #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_n     (cmd_n),
      .cnt_pulse (cnt_pulse),
      .cnt_rst   (cnt_rst),
      .cnt_q     (cnt_q),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_value (rsp_value),
      .rsp_err   (rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Ripple counter model clocked by cnt_pulse; pulse number drop_at is lost.
   always @(posedge cnt_pulse or posedge cnt_rst) begin
      if (cnt_rst) begin
         cnt_q <= '0;
      end else begin
         pulses_seen <= pulses_seen + 1;
         if (pulses_seen + 1 != drop_at) cnt_q <= cnt_q + 1'b1;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      compared++;
      assert (obs === expv) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   // Issue one command, observe pulses/clears per cycle, check the response.
   task automatic do_cmd(input logic op, input int n, input int drop, input int hold);
      exp_t        e;
      exp_t        got;
      int          tgt;
      int          waited;
      int          k;
      logic [63:0] pm;
      logic [63:0] rm;
      e.pmask = '0;
      e.rmask = '0;
      if (op == OP_CLEAR) begin
         hw_m    = 0;
         tgt     = 0;
         e.lat   = SETTLE + 3;
         e.rmask = 64'b110;
      end else begin
         tgt   = (exp_m + n) % 16;
         hw_m  = (hw_m + n - drop) % 16;
         e.lat = (n > 0) ? 2 * n + SETTLE + 1 : SETTLE + 1;
         for (int i = 0; i < n; i++) e.pmask |= 64'd1 << (2 * i + 1);
      end
      e.val = hw_m[WIDTH-1:0];
      e.err = (hw_m != tgt);
      exp_m = hw_m;
      sb.push_back(e);

      drop_at = (drop != 0) ? pulses_seen + 2 : -1;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_n     = n[WIDTH-1:0];
      waited    = 0;
      while (!cmd_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      check("accept_timeout", 64'(waited < 50), 64'd1);

      k  = 0;
      pm = '0;
      rm = '0;
      while (k < 200) begin
         @(negedge clk);
         k++;
         if (k == 1) cmd_valid = 1'b0;
         if (cnt_pulse && k < 64) pm |= 64'd1 << k;
         if (cnt_rst && k < 64) rm |= 64'd1 << k;
         if (rsp_valid) break;
      end
      got = sb.pop_front();
      check("rsp_latency", 64'(k), 64'(got.lat));
      check("pulse_cycles", pm, got.pmask);
      check("clear_cycles", rm, got.rmask);
      check("rsp_value", 64'(rsp_value), 64'(got.val));
      check("rsp_err", 64'(rsp_err), 64'(got.err));

      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_stable", {58'd0, rsp_valid, rsp_value, rsp_err},
               {58'd0, 1'b1, got.val, got.err});
         check("hold_quiet", {61'd0, cmd_ready, cnt_pulse, cnt_rst}, 64'd0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("rsp_release", {62'd0, rsp_valid, cmd_ready}, 64'b01);
   endtask

   initial begin
      int seen_valid;
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = 1'b0;
      cmd_n     = '0;
      rsp_ready = 1'b0;
      drop_at   = -1;
      exp_m     = 0;
      hw_m      = 0;

      // Reset state and release timing
      repeat (3) @(negedge clk);
      check("reset_outputs", {56'd0, cnt_rst, cnt_pulse, cmd_ready, rsp_valid, rsp_value},
            {56'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0});
      rst_n = 1'b1;
      #1;
      check("init_cycle0", {62'd0, cnt_rst, cmd_ready}, 64'b10);
      @(negedge clk);
      check("init_cycle1", {61'd0, cnt_rst, cmd_ready, rsp_valid}, 64'b010);

      // Clear, count, wrap, sample-only
      do_cmd(OP_CLEAR, 0, 0, 0);
      do_cmd(OP_COUNT, 5, 0, 0);
      do_cmd(OP_CLEAR, 0, 0, 0);
      do_cmd(OP_COUNT, 15, 0, 0);
      do_cmd(OP_COUNT, 3, 0, 0);
      do_cmd(OP_COUNT, 0, 0, 0);

      // Dropped pulse then resync
      do_cmd(OP_CLEAR, 0, 0, 0);
      do_cmd(OP_COUNT, 3, 1, 0);
      do_cmd(OP_COUNT, 1, 0, 0);

      // Response back-pressure
      do_cmd(OP_COUNT, 2, 0, 10);

      // Reset during the third pulse of COUNT 8
      @(negedge clk);
      check("mid_ready", 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b1;
      cmd_op    = OP_COUNT;
      cmd_n     = 4'd8;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         if (k == 1) cmd_valid = 1'b0;
      end
      check("mid_pulse3", 64'(cnt_pulse), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_reset", {60'd0, cnt_pulse, cnt_rst, rsp_valid, cmd_ready}, 64'b0100);
      hw_m  = 0;
      exp_m = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("mid_init_cycle0", 64'(cnt_rst), 64'd1);
      seen_valid = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (rsp_valid) seen_valid++;
      end
      check("mid_no_rsp", 64'(seen_valid), 64'd0);
      do_cmd(OP_COUNT, 2, 0, 0);

      check("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
